// File: rtl/tb_pkg.sv
// rtl/tb_pkg.sv - shared types and default geometry for the traceback pointer packer
package tb_pkg;

    localparam int PTR_WIDTH_DEF  = 2;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int LANES          = DATA_WIDTH_DEF / PTR_WIDTH_DEF;
    localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } tb_state_e;

    typedef logic [PTR_WIDTH_DEF-1:0] tb_ptr_t;

endpackage

// File: rtl/tb_ptr_packer.sv
// rtl/tb_ptr_packer.sv - packs traceback pointers into BRAM words, then lends the port to the reader
module tb_ptr_packer
    import tb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PTR_WIDTH  = PTR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PTR_WIDTH-1:0]  in_ptr,
    input  logic                  in_last,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_write_en,
    output logic [DATA_WIDTH-1:0] bram_data_in,
    input  logic [DATA_WIDTH-1:0] bram_data_out,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  done,
    output logic                  overflow
);

    localparam int NUM_LANES = DATA_WIDTH / PTR_WIDTH;
    localparam int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LW-1:0]       LAST_LANE = LW'(NUM_LANES - 1);
    localparam logic [ADDR_WIDTH:0] NUM_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    tb_state_e             state, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [LW-1:0]         lane_cnt;
    logic [DATA_WIDTH-1:0] pack_reg, pack_next;
    logic                  rd_pend;
    logic                  full, accept, commit, ovf_hit, rd_go;

    assign full     = (words_written == NUM_WORDS);
    assign in_ready = (state == FILL) && !full;
    assign rd_ready = (state == IDLE) || (state == DONE);
    assign rd_data  = bram_data_out;

    // start outranks everything in the same cycle: no accept, no read launch
    assign accept  = in_valid && in_ready && !start;
    assign commit  = accept && (in_last || (lane_cnt == LAST_LANE));
    assign ovf_hit = (state == FILL) && full && in_valid && !start;
    assign rd_go   = rd_ready && rd_en && !start;

    always_comb begin
        pack_next = pack_reg;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_cnt == LW'(i)) begin
                pack_next[i*PTR_WIDTH +: PTR_WIDTH] = in_ptr;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (start) state_d = FILL;
            FILL: begin
                if (start)                    state_d = FILL;
                else if (commit && in_last)   state_d = DONE;
                else if (ovf_hit)             state_d = DONE;
            end
            DONE: if (start) state_d = FILL;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            words_written <= '0;
            lane_cnt      <= '0;
            pack_reg      <= '0;
            bram_addr     <= '0;
            bram_write_en <= 1'b0;
            bram_data_in  <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            rd_pend       <= 1'b0;
            rd_valid      <= 1'b0;
        end else begin
            bram_write_en <= 1'b0;
            done          <= (state == FILL) && (state_d == DONE);
            rd_pend       <= rd_go;
            rd_valid      <= rd_pend;

            if (start) begin
                wr_ptr        <= '0;
                words_written <= '0;
                lane_cnt      <= '0;
                pack_reg      <= '0;
                overflow      <= 1'b0;
            end else if (state == FILL) begin
                if (commit) begin
                    bram_write_en <= 1'b1;
                    bram_addr     <= wr_ptr;
                    bram_data_in  <= pack_next;
                    wr_ptr        <= wr_ptr + 1'b1;
                    words_written <= words_written + 1'b1;
                    lane_cnt      <= '0;
                    pack_reg      <= '0;
                end else if (accept) begin
                    lane_cnt <= lane_cnt + 1'b1;
                    pack_reg <= pack_next;
                end
                if (ovf_hit) overflow <= 1'b1;
            end

            // the read address shares the write address register
            if (rd_go) bram_addr <= rd_addr;
        end
    end

endmodule

// File: doc/tb_ptr_packer.md
Name: tb_ptr_packer

Overview:
- Write-side controller directly upstream of the traceback pointer BRAM. That BRAM is single-port, 1-cycle registered read, and has no reset.
- Accepts a stream of PTR_WIDTH-bit traceback pointers from the X-Drop PE array and packs them into DATA_WIDTH-bit words. Drives the BRAM addr/write_en/data_in with sequential addresses.
- After a tile completes, muxes the same single port over to the traceback read requester.

Parameters:
- ADDR_WIDTH, 8, BRAM address width; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, BRAM word width.
- PTR_WIDTH, 2, width of one traceback pointer; LANES = DATA_WIDTH/PTR_WIDTH (must divide exactly; 8 at defaults).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  begin new tile; clears counters and flags
- in_valid  in  1  pointer valid
- in_ready  out  1  pointer accepted when in_valid&&in_ready
- in_ptr  in  PTR_WIDTH  traceback pointer
- in_last  in  1  qualifies the final pointer of the tile
- rd_en  in  1  read request (honoured only when rd_ready)
- rd_addr  in  ADDR_WIDTH  read word address
- rd_ready  out  1  read port available (IDLE or DONE)
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_WIDTH  read word (combinational pass of bram_data_out)
- bram_addr  out  ADDR_WIDTH  to BRAM addr
- bram_write_en  out  1  to BRAM write_en
- bram_data_in  out  DATA_WIDTH  to BRAM data_in
- bram_data_out  in  DATA_WIDTH  from BRAM data_out
- words_written  out  ADDR_WIDTH+1  words committed this tile
- done  out  1  one-cycle pulse at tile completion
- overflow  out  1  sticky: pointer offered while memory full

Behaviour:
- Reset: one clock and a single reset. rst_n is synchronous and active-low, sampled on posedge clk.
- Reset values: state=IDLE; every output 0 (bram_addr, bram_write_en, bram_data_in, words_written, done, overflow, rd_valid, in_ready). Lane counter and pack register are also 0.
- States are IDLE, FILL and DONE.
- IDLE:
  - in_ready=0, rd_ready=1.
  - start moves to FILL and clears wr_ptr, words_written, lane_cnt, pack register and overflow.
- FILL:
  - in_ready=1 while words_written<DEPTH; rd_ready=0; rd_en is ignored.
  - On accept, in_ptr goes into lane lane_cnt at bits [lane_cnt*PTR_WIDTH +: PTR_WIDTH]. The first pointer of a word is lane 0.
- Word commit: occurs when lane_cnt==LANES-1, or when in_last is accepted.
  - Next cycle: bram_write_en=1 for exactly one cycle, bram_addr=wr_ptr, bram_data_in=packed word.
  - Unfilled lanes are 0.
  - wr_ptr, words_written and lane_cnt update accordingly; the pack register clears.
  - Latency from accept to write strobe is 1 cycle. Back-to-back accepts sustain 1 pointer/cycle.
- in_last: after its commit cycle, go to DONE.
  - If in_last arrives exactly at lane 0 of a new word, that single pointer is still written as a word.
- Full: when words_written==DEPTH, in_ready=0.
  - A cycle with in_valid=1 while full sets overflow=1 and goes to DONE.
  - The pending partial word is discarded (it is always empty at full).
  - wr_ptr wrap is never used.
- DONE:
  - done=1 on the first cycle only.
  - rd_ready=1. start re-enters FILL with counters cleared. overflow holds until start or reset.
- start in FILL: abort. Go back to a fresh FILL; the partial word is dropped and no write is issued.
  - A commit already registered in the same cycle still completes.
- Read path (IDLE/DONE only):
  - rd_en registers bram_addr<=rd_addr with bram_write_en=0.
  - rd_valid=1 two cycles after rd_en, because both the address register and the BRAM register sit in the path.
  - Back-to-back reads are pipelined at one per cycle.
  - start on the same cycle as rd_en: start wins and the read is dropped.
  - An in-flight rd_valid still fires.
- in_valid in IDLE/DONE is ignored (no accept).
- Mid-operation reset returns to IDLE immediately; BRAM contents are undefined to the consumer.

Decomposition:
- Package tb_pkg holds:
  - state enum tb_state_e {IDLE, FILL, DONE};
  - localparams LANES and DEPTH;
  - the pointer type tb_ptr_t (logic [PTR_WIDTH-1:0]).
- No sub-module is needed. The packer, the FSM and the port mux are a single module. The BRAM is instantiated one level up beside this block.

Test Plan:
- Full word: start, then ptrs 1,2,3,0,1,2,3,0 on consecutive cycles, last on the 8th → one write, addr 0, data 0x3939, the cycle after the 8th accept; done pulse; words_written=1.
- Partial word: start, ptrs 3,3,1 with in_last on the 3rd → write addr 0 data 0x001F; DONE.
- Gapped stream: 16 ptrs all =2 with in_valid toggling every other cycle → writes addr 0 and 1, each data 0xAAAA; no extra strobes.
- Overflow at ADDR_WIDTH=2: 32 ptrs fill 4 words, then in_valid held without in_last → in_ready=0 after the 4th write; overflow=1; DONE; words_written=4.
- Readback: after the full-word test, rd_en with rd_addr=0 → bram_addr=0 next cycle; rd_valid=1 with rd_data=0x3939 two cycles after rd_en; rd_en in FILL gives no rd_valid.
- Abort and reset: 5 ptrs, then start → no write and lane_cnt restarts. Then 3 ptrs and rst_n=0 → all outputs 0 and IDLE next cycle.
